// File: rtl/comparador_serial_msb_if.sv
// Request/result bundle for the serial MSB-first comparator.
// The master drives the operands and start; the slave returns status and results.
// Parameter N must match the operand width of the comparator it connects to.
interface comparador_serial_msb_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [1:0]   mode;
  logic         sgn;
  logic         busy;
  logic         done;
  logic         Zout;
  logic         gt;
  logic         lt;
  logic         eq;

  modport master (
    output start, A, B, mode, sgn,
    input  busy, done, Zout, gt, lt, eq
  );

  modport slave (
    input  start, A, B, mode, sgn,
    output busy, done, Zout, gt, lt, eq
  );
endinterface

// File: rtl/comparador_serial_msb.sv
// Serial MSB-first magnitude comparator: K bits per cycle, P/Q relation kept in a register.
// Latency: N/K cycles from the start edge to done, or fewer with EARLY_EXIT once decided.
// Backpressure: none; start is only accepted in IDLE/DONE and ignored while busy.
module comparador_serial_msb #(
  parameter int N          = 8,
  parameter int K          = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  comparador_serial_msb_if.slave   bus
);

  localparam int STEPS = N / K;
  localparam int CW    = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [1:0]    r_mode;
  logic [1:0]    r_pq;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_zout;
  logic          r_gt;
  logic          r_lt;
  logic          r_eq;

  logic [K-1:0]  w_a;
  logic [K-1:0]  w_b;
  logic [1:0]    w_pq_nxt;
  logic          w_last;
  logic          w_term;
  logic          w_gt;
  logic          w_lt;
  logic          w_eq;
  logic          w_zsel;
  logic [N-1:0]  w_msk;

  // Current chunk is always the top K bits; the shift registers bring the next chunk up.
  assign w_a = r_sa[N-1 -: K];
  assign w_b = r_sb[N-1 -: K];

  // Flipping the MSB of both operands maps two's-complement order onto unsigned order.
  assign w_msk = {bus.sgn, {(N-1){1'b0}}};

  // Relation update: only an undecided (00) state looks at the chunk; a decision is sticky.
  always_comb begin
    w_pq_nxt = r_pq;
    if (r_pq == 2'b00) begin
      if (w_a > w_b)      w_pq_nxt = 2'b10;
      else if (w_a < w_b) w_pq_nxt = 2'b01;
    end
  end

  assign w_gt   = w_pq_nxt[1];
  assign w_lt   = w_pq_nxt[0];
  assign w_eq   = ~(w_pq_nxt[1] | w_pq_nxt[0]);
  assign w_last = (r_cnt == CW'(STEPS - 1));
  assign w_term = w_last || ((EARLY_EXIT != 0) && (w_pq_nxt != 2'b00));

  // Result select from the latched mode, computed from the relation being written.
  always_comb begin
    w_zsel = 1'b0;
    case (r_mode)
      2'b00:   w_zsel = w_gt;
      2'b01:   w_zsel = w_lt;
      2'b10:   w_zsel = w_eq;
      default: w_zsel = w_gt | w_eq;
    endcase
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_mode  <= 2'b00;
      r_pq    <= 2'b00;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zout  <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sa    <= bus.A ^ w_msk;
            r_sb    <= bus.B ^ w_msk;
            r_mode  <= bus.mode;
            r_pq    <= 2'b00;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_zout  <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_pq  <= w_pq_nxt;
          r_sa  <= r_sa << K;
          r_sb  <= r_sb << K;
          r_cnt <= r_cnt + 1'b1;
          if (w_term) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_gt    <= w_gt;
            r_lt    <= w_lt;
            r_eq    <= w_eq;
            r_zout  <= w_zsel;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.Zout = r_zout;
  assign bus.gt   = r_gt;
  assign bus.lt   = r_lt;
  assign bus.eq   = r_eq;

endmodule

// File: tb/tb_comparador_serial_msb.sv
// Directed bench for the serial MSB-first comparator across several K/EARLY_EXIT builds.
// Four instances share clock and reset; each scenario drives one of them.
// Outputs are sampled on the falling edge, inputs also change on the falling edge.
module tb_comparador_serial_msb;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  comparador_serial_msb_if #(.N(8)) if_a ();
  comparador_serial_msb_if #(.N(8)) if_b ();
  comparador_serial_msb_if #(.N(8)) if_c ();
  comparador_serial_msb_if #(.N(8)) if_d ();

  // a: K=1 full length, b: K=1 early exit, c: K=2 early exit, d: K=4 full length
  comparador_serial_msb #(.N(8), .K(1), .EARLY_EXIT(0)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  comparador_serial_msb #(.N(8), .K(1), .EARLY_EXIT(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  comparador_serial_msb #(.N(8), .K(2), .EARLY_EXIT(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));
  comparador_serial_msb #(.N(8), .K(4), .EARLY_EXIT(0)) dut_d (.clk(clk), .reset(reset), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the request side of one instance.
  task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m, input logic s);
    case (sel)
      0: begin if_a.start = st; if_a.A = a; if_a.B = b; if_a.mode = m; if_a.sgn = s; end
      1: begin if_b.start = st; if_b.A = a; if_b.B = b; if_b.mode = m; if_b.sgn = s; end
      2: begin if_c.start = st; if_c.A = a; if_c.B = b; if_c.mode = m; if_c.sgn = s; end
      default: begin if_d.start = st; if_d.A = a; if_d.B = b; if_d.mode = m; if_d.sgn = s; end
    endcase
  endtask

  // Status/result vector {busy, done, Zout, gt, lt, eq} of one instance.
  function automatic logic [5:0] outs(input int sel);
    case (sel)
      0:       return {if_a.busy, if_a.done, if_a.Zout, if_a.gt, if_a.lt, if_a.eq};
      1:       return {if_b.busy, if_b.done, if_b.Zout, if_b.gt, if_b.lt, if_b.eq};
      2:       return {if_c.busy, if_c.done, if_c.Zout, if_c.gt, if_c.lt, if_c.eq};
      default: return {if_d.busy, if_d.done, if_d.Zout, if_d.gt, if_d.lt, if_d.eq};
    endcase
  endfunction

  // One-cycle start pulse; returns at the falling edge just after the accepting edge.
  task automatic pulse_start(input int sel, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] m, input logic s);
    @(negedge clk);
    drive(sel, 1'b1, a, b, m, s);
    @(negedge clk);
    drive(sel, 1'b0, a, b, m, s);
  endtask

  // Counts edges after the start edge until done is seen; 0 means the budget ran out.
  task automatic wait_done(input int sel, output int lat);
    logic [5:0] o;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      o = outs(sel);
      if (o[4]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [5:0] o;
    reset = 1'b1;
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    #1;
    for (int s = 0; s < 4; s++) begin
      o = outs(s);
      checks++;
      if (o !== 6'b000000) begin
        errors++;
        $display("FAIL reset_outs dut%0d: got %b expected 000000", s, o);
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    o = outs(0);
    checks++;
    if (o !== 6'b000000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000000", o);
    end
  endtask

  task automatic test_equal_full;
    int lat;
    logic [5:0] o;
    pulse_start(0, 8'h5A, 8'h5A, 2'b10, 1'b0);
    o = outs(0);
    checks++;
    if (o[5] !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_run: got %b expected 1", o[5]);
    end
    wait_done(0, lat);
    o = outs(0);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL eq_latency: got %0d expected 8", lat);
    end
    checks++;
    if (o !== 6'b011001) begin
      errors++;
      $display("FAIL eq_result: got %b expected 011001", o);
    end
    @(negedge clk);
    o = outs(0);
    checks++;
    if (o !== 6'b001001) begin
      errors++;
      $display("FAIL eq_done_pulse_hold: got %b expected 001001", o);
    end
  endtask

  task automatic test_early_exit;
    int lat;
    logic [5:0] o;
    pulse_start(1, 8'h80, 8'h7F, 2'b00, 1'b0);
    wait_done(1, lat);
    o = outs(1);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL early_latency: got %0d expected 1", lat);
    end
    checks++;
    if (o !== 6'b011100) begin
      errors++;
      $display("FAIL early_result: got %b expected 011100", o);
    end
    pulse_start(0, 8'h80, 8'h7F, 2'b00, 1'b0);
    wait_done(0, lat);
    o = outs(0);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL full_latency: got %0d expected 8", lat);
    end
    checks++;
    if (o !== 6'b011100) begin
      errors++;
      $display("FAIL full_result: got %b expected 011100", o);
    end
  endtask

  task automatic test_signed_k2;
    int lat;
    logic [5:0] o;
    // Signed: -1 < 1, decided on the first 2-bit chunk.
    pulse_start(2, 8'hFF, 8'h01, 2'b01, 1'b1);
    wait_done(2, lat);
    o = outs(2);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL signed_latency: got %0d expected 1", lat);
    end
    checks++;
    if (o !== 6'b011010) begin
      errors++;
      $display("FAIL signed_result: got %b expected 011010", o);
    end
    // Unsigned: 255 > 1, so A<B is false.
    pulse_start(2, 8'hFF, 8'h01, 2'b01, 1'b0);
    wait_done(2, lat);
    o = outs(2);
    checks++;
    if (o !== 6'b010100) begin
      errors++;
      $display("FAIL unsigned_result: got %b expected 010100", o);
    end
  endtask

  task automatic test_k4_ignore_start;
    int lat;
    logic [5:0] o;
    pulse_start(3, 8'h3C, 8'h3D, 2'b11, 1'b0);
    // A start with very different operands while running must be ignored.
    drive(3, 1'b1, 8'hFF, 8'h00, 2'b00, 1'b0);
    @(negedge clk);
    drive(3, 1'b0, 8'hFF, 8'h00, 2'b00, 1'b0);
    lat = 1;
    o = outs(3);
    if (!o[4]) begin
      wait_done(3, lat);
      if (lat != 0) lat = lat + 1;
      o = outs(3);
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL k4_latency: got %0d expected 2", lat);
    end
    checks++;
    if (o !== 6'b010010) begin
      errors++;
      $display("FAIL k4_result: got %b expected 010010", o);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [5:0] o;
    pulse_start(0, 8'h20, 8'h10, 2'b00, 1'b0);
    wait_done(0, lat);
    o = outs(0);
    checks++;
    if (o !== 6'b011100 || lat != 8) begin
      errors++;
      $display("FAIL b2b_first: got %b lat %0d expected 011100 lat 8", o, lat);
    end
    // Second request presented in the done cycle.
    drive(0, 1'b1, 8'h10, 8'h20, 2'b01, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h10, 8'h20, 2'b01, 1'b0);
    o = outs(0);
    checks++;
    if (o !== 6'b100000) begin
      errors++;
      $display("FAIL b2b_no_idle: got %b expected 100000", o);
    end
    wait_done(0, lat);
    o = outs(0);
    checks++;
    if (o !== 6'b011010 || lat != 8) begin
      errors++;
      $display("FAIL b2b_second: got %b lat %0d expected 011010 lat 8", o, lat);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    int pulses;
    logic [5:0] o;
    pulse_start(0, 8'h00, 8'h01, 2'b10, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    o = outs(0);
    checks++;
    if (o !== 6'b000000) begin
      errors++;
      $display("FAIL async_reset_drop: got %b expected 000000", o);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      o = outs(0);
      if (o[4]) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL async_reset_no_done: got %0d pulses expected 0", pulses);
    end
    pulse_start(0, 8'h03, 8'h02, 2'b00, 1'b0);
    wait_done(0, lat);
    o = outs(0);
    checks++;
    if (o !== 6'b011100 || lat != 8) begin
      errors++;
      $display("FAIL after_reset_run: got %b lat %0d expected 011100 lat 8", o, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_equal_full();
    test_early_exit();
    test_signed_k2();
    test_k4_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
